// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out bit serializer with valid/ready word input.
// Optional even-parity trailer bit enabled by defining SER_PARITY_EN.
module piso_bit_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  d_out,
    output logic                  d_valid,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  d_out_q, d_out_d;
    logic                  d_valid_q, d_valid_d;
    logic                  busy_q, busy_d;
`ifdef SER_PARITY_EN
    logic                  par_q, par_d;
`endif

    logic accept;
    logic last_bit;

    function automatic logic head(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign accept   = in_valid && in_ready;
    assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    // State register (datapath flops share the same reset)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            cnt_q     <= '0;
            d_out_q   <= 1'b0;
            d_valid_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SER_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            cnt_q     <= cnt_d;
            d_out_q   <= d_out_d;
            d_valid_q <= d_valid_d;
            busy_q    <= busy_d;
`ifdef SER_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = SHIFT;
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
`ifdef SER_PARITY_EN
                    state_d = PAR;
`else
                    state_d = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef SER_PARITY_EN
            PAR: begin
                state_d = accept ? SHIFT : IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        d_out_d   = 1'b0;
        d_valid_d = 1'b0;
        busy_d    = 1'b0;
`ifdef SER_PARITY_EN
        par_d     = par_q;
`endif
        if (accept) begin
            sreg_d    = advance(in_data);
            cnt_d     = CW'(1);
            d_out_d   = head(in_data);
            d_valid_d = 1'b1;
            busy_d    = 1'b1;
`ifdef SER_PARITY_EN
            par_d     = ^in_data;
`endif
        end else if ((state_q == SHIFT) && !last_bit) begin
            sreg_d    = advance(sreg_q);
            cnt_d     = cnt_q + CW'(1);
            d_out_d   = head(sreg_q);
            d_valid_d = 1'b1;
            busy_d    = 1'b1;
`ifdef SER_PARITY_EN
        end else if (last_bit) begin
            // Counter holds at DATA_WIDTH through the parity cycle
            d_out_d   = par_q;
            d_valid_d = 1'b1;
            busy_d    = 1'b1;
`endif
        end else begin
            cnt_d = '0;
        end
    end

    // Output logic
    always_comb begin
`ifdef SER_PARITY_EN
        in_ready = (state_q == IDLE) || (state_q == PAR);
`else
        in_ready = (state_q == IDLE) || last_bit;
`endif
    end

    assign d_out   = d_out_q;
    assign d_valid = d_valid_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Directed bench for piso_bit_serializer: MSB-first and LSB-first instances
// checked every cycle against a bit-queue model, plus literal stream checks.
module tb_piso_bit_serializer;

`ifdef SER_PARITY_EN
    localparam int FR = 9;
`else
    localparam int FR = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b1;
    logic [7:0] in_data = 8'hA5;

    logic rdy_m, dout_m, dv_m, busy_m;
    logic rdy_l, dout_l, dv_l, busy_l;

    int tests = 0;
    int fails = 0;

    bit q_m[$];
    bit q_l[$];
    bit got_m[$];
    bit got_l[$];
    bit live = 1'b0;

    always #5 clk = ~clk;

    piso_bit_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_m), .d_out(dout_m), .d_valid(dv_m), .busy(busy_m)
    );

    piso_bit_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_l), .d_out(dout_l), .d_valid(dv_l), .busy(busy_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of bits still to appear; front is the bit on the wire
    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            q_m.delete();
            q_l.delete();
            live = 1'b1;
        end else begin
            acc = in_valid && (q_m.size() <= 1);
            if (q_m.size() > 0) void'(q_m.pop_front());
            if (q_l.size() > 0) void'(q_l.pop_front());
            if (acc) begin
                for (int i = 0; i < 8; i++) begin
                    q_m.push_back(in_data[7-i]);
                    q_l.push_back(in_data[i]);
                end
`ifdef SER_PARITY_EN
                q_m.push_back(^in_data);
                q_l.push_back(^in_data);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("msb d_valid", dv_m, q_m.size() > 0);
            check("msb busy", busy_m, q_m.size() > 0);
            check("msb d_out", dout_m, (q_m.size() > 0) ? q_m[0] : 1'b0);
            check("msb in_ready", rdy_m, q_m.size() <= 1);
            check("lsb d_valid", dv_l, q_l.size() > 0);
            check("lsb busy", busy_l, q_l.size() > 0);
            check("lsb d_out", dout_l, (q_l.size() > 0) ? q_l[0] : 1'b0);
            check("lsb in_ready", rdy_l, q_l.size() <= 1);
            if (dv_m) got_m.push_back(dout_m);
            if (dv_l) got_l.push_back(dout_l);
        end
    end

    function automatic logic [7:0] pk_m(input int off);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++)
            if (off + i < got_m.size()) v[7-i] = got_m[off+i];
        return v;
    endfunction

    function automatic logic [7:0] pk_l(input int off);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++)
            if (off + i < got_l.size()) v[i] = got_l[off+i];
        return v;
    endfunction

    task automatic clear_logs();
        got_m.delete();
        got_l.delete();
    endtask

    // Present a word and hold it until in_ready lets the next edge take it
    task automatic send(input logic [7:0] w);
        bit done = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        for (int n = 0; n < 40 && !done; n++) begin
            if (rdy_m) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send timeout: word %0h not accepted", w);
        end
    endtask

    task automatic drop();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        // 1: reset with in_valid high
        repeat (2) @(negedge clk);
        check("reset d_valid", dv_m, 1'b0);
        check("reset d_out", dout_m, 1'b0);
        check("reset busy", busy_m, 1'b0);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", rdy_m, 1'b1);
        check("nothing accepted in reset", got_m.size(), 0);

        // 2: single word
        clear_logs();
        send(8'hA5);
        drop();
        repeat (12) @(negedge clk);
        check("A5 frame length", got_m.size(), FR);
        check("A5 msb stream", pk_m(0), 8'hA5);
        check("A5 lsb stream", pk_l(0), 8'hA5);
        check("idle d_out", dout_m, 1'b0);

        // 3: back-to-back words
        clear_logs();
        send(8'hA5);
        send(8'h3C);
        drop();
        repeat (20) @(negedge clk);
        check("b2b length", got_m.size(), 2 * FR);
        check("b2b word0", pk_m(0), 8'hA5);
        check("b2b word1", pk_m(FR), 8'h3C);

        // 4: in_data changes while not ready
        clear_logs();
        send(8'h11);
        @(negedge clk);
        in_data = 8'hEE;
        repeat (3) @(negedge clk);
        in_data = 8'h5A;
        send(8'h5A);
        drop();
        repeat (20) @(negedge clk);
        check("hold word0", pk_m(0), 8'h11);
        check("hold word1", pk_m(FR), 8'h5A);
        check("hold lsb word1", pk_l(FR), 8'h5A);

        // 5: reset mid-word
        clear_logs();
        send(8'hFF);
        drop();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid reset d_valid", dv_m, 1'b0);
        repeat (3) @(negedge clk);
        check("mid reset bits", got_m.size(), 3);
        clear_logs();
        send(8'h3C);
        drop();
        repeat (12) @(negedge clk);
        check("after reset word", pk_m(0), 8'h3C);
        check("after reset length", got_m.size(), FR);

        // 6: LSB-first with optional parity
        clear_logs();
        send(8'h07);
        drop();
        repeat (12) @(negedge clk);
        check("07 lsb stream", pk_l(0), 8'h07);
        check("07 lsb length", got_l.size(), FR);
`ifdef SER_PARITY_EN
        check("07 parity", got_l[8], 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
